hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage CPU. It replaces the single-cycle load-use check with several functions:
- a multi-cycle load-use stall counter, sized for memory read latency;
- a multiply/divide unit busy-dependency interlock;
- taken-branch IF/ID flush;
- a sticky HALT state.
It sits beside the ID stage and drives PC write-enable, IF/ID write-enable, ID/EX bubble insertion and IF/ID flush. It also keeps a saturating stall-cycle counter.

Parameters:
REG_AW, 4, register-address width (2**REG_AW architectural registers)
LOAD_LAT, 1, stall cycles per load-use hazard (>=1; 1 = classic one-bubble stall)
ZERO_REG, 0, 1 = register 0 hardwired zero, never creates a dependency
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_rs1  in  REG_AW  ID-stage source register 1
id_rs2  in  REG_AW  ID-stage source register 2
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a load
md_busy  in  1  multiply/divide unit executing
md_rd  in  REG_AW  destination of in-flight mul/div
branch_taken  in  1  branch in EX resolved taken
halt_op  in  1  ID instruction decodes as HALT
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register enable
idex_bubble  out  1  zero ID/EX control fields (insert NOP)
ifid_flush  out  1  clear IF/ID to NOP
halted  out  1  core halted
stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- dep(r) = (r==id_rs1 && id_rs1_used) || (r==id_rs2 && id_rs2_used). When ZERO_REG=1, dep(0)=0.
- load_haz = ex_mem_read && dep(ex_rd).
- md_haz = md_busy && dep(md_rd).
- FSM states RUN, STALL, HALT. Registered down-counter scnt, width clog2(LOAD_LAT+1).
- Outputs are combinational from state and inputs. Default: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, halted=0.
- RUN, evaluated in priority order:
  1. branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1. No stall or halt starts, even if load_haz or halt_op is high (the ID instruction is killed). Stay in RUN.
  2. load_haz: pc_write=0, ifid_write=0, idex_bubble=1. If LOAD_LAT>1, go to STALL with scnt=LOAD_LAT-1; otherwise stay in RUN.
  3. md_haz: pc_write=0, ifid_write=0, idex_bubble=1 while the condition holds. No counter; stay in RUN.
  4. halt_op: go to HALT next cycle. The current cycle uses default outputs, so HALT enters ID/EX.
- STALL:
  - pc_write=0, ifid_write=0, idex_bubble=1, regardless of hazard inputs.
  - scnt decrements each cycle; when scnt==1, next state is RUN.
  - branch_taken in STALL aborts the stall: flush outputs as in RUN, next state RUN, scnt=0.
  - halt_op is ignored in STALL; the HALT is still held in ID and is re-evaluated in RUN.
- HALT: pc_write=0, ifid_write=0, idex_bubble=1, halted=1. All inputs are ignored. Exit only via reset.
- stall_cycles increments by 1 on every clk edge where pc_write==0 && state!=HALT. It saturates at all-ones and does not wrap.
- Reset (rst_n=0, asynchronous): state=RUN, scnt=0, stall_cycles=0. Outputs are forced to pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, halted=0 while rst_n=0. Reset mid-STALL or in HALT returns to RUN immediately.
- Release of rst_n is synchronised externally; the block assumes a clean deassertion.

Decomposition:
- Shared package cpu_pkg: REG_AW default, the state typedef (RUN/STALL/HALT) and the NOP opcode constant used by the pipeline flush logic.
- One natural sub-module, hazard_dep_cmp: a combinational two-source match with zero-register masking. It is instantiated twice, once for ex_rd and once for md_rd.

Test Plan:
- LOAD_LAT=1: ex_mem_read=1, ex_rd=3, id_rs1=3, id_rs1_used=1 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; next cycle (hazard cleared) defaults; stall_cycles=1.
- LOAD_LAT=3: same hazard pulsed one cycle -> stall outputs for exactly 3 cycles (RUN, STALL, STALL), then RUN; stall_cycles=3.
- ZERO_REG=1: ex_mem_read=1, ex_rd=0, id_rs2=0, id_rs2_used=1 -> no stall. Same stimulus with ZERO_REG=0 -> one stall cycle.
- load_haz and branch_taken in the same cycle -> ifid_flush=1, pc_write=1, no STALL entry. branch_taken in the 2nd cycle of a LOAD_LAT=3 stall -> flush, RUN next cycle.
- md_busy=1, md_rd=5, id_rs1=5 held 4 cycles, then md_busy=0 -> 4 stall cycles, then defaults. halt_op=1 during this md stall, with only halt_op held afterwards -> HALT entered one cycle after the md stall ends; halted=1 persists until rst_n pulses low, which restores defaults asynchronously.
- CNT_W=4: force 20 stall cycles -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: register-file sizing, hazard FSM states, NOP encoding.
package cpu_pkg;

   localparam int unsigned REG_AW_DEF = 4;

   // addi x0, x0, 0 -- written into IF/ID when the pipeline flushes
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_HALT  = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_dep_cmp.sv
// Combinational match of one producer register against the two ID-stage sources.
module hazard_dep_cmp import cpu_pkg::*; #(
   parameter int unsigned REG_AW   = REG_AW_DEF,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic [REG_AW-1:0] rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic              rs1_used,
   input  logic              rs2_used,
   output logic              hit_c
);

   // A hardwired-zero destination can never feed a real value forward
   always_comb begin
      hit_c = ((rd == rs1) && rs1_used) || ((rd == rs2) && rs2_used);
      if ((ZERO_REG != 0) && (rd == '0)) hit_c = 1'b0;
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use stall, mul/div interlock, branch flush, sticky halt.
module hazard_stall_ctrl import cpu_pkg::*; #(
   parameter int unsigned REG_AW   = REG_AW_DEF,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned ZERO_REG = 0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              md_busy,
   input  logic [REG_AW-1:0] md_rd,
   input  logic              branch_taken,
   input  logic              halt_op,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int unsigned        SCNT_W    = $clog2(LOAD_LAT + 1);
   localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(LOAD_LAT - 1);

   hz_state_t         state, state_nxt;
   logic [SCNT_W-1:0] scnt, scnt_nxt;
   logic              load_dep, md_dep;
   logic              load_haz, md_haz;

   hazard_dep_cmp #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_load_cmp (
      .rd       (ex_rd),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .rs1_used (id_rs1_used),
      .rs2_used (id_rs2_used),
      .hit_c    (load_dep)
   );

   hazard_dep_cmp #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_md_cmp (
      .rd       (md_rd),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .rs1_used (id_rs1_used),
      .rs2_used (id_rs2_used),
      .hit_c    (md_dep)
   );

   assign load_haz = ex_mem_read && load_dep;
   assign md_haz   = md_busy && md_dep;

   // State and load-latency countdown registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         scnt  <= '0;
      end else begin
         state <= state_nxt;
         scnt  <= scnt_nxt;
      end
   end

   // Next-state and pipeline-control decode; reset holds the pipeline in free-run
   always_comb begin
      state_nxt   = state;
      scnt_nxt    = scnt;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      halted      = 1'b0;
      if (rst_n) begin
         case (state)
            ST_RUN: begin
               if (branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (load_haz) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_nxt = ST_STALL;
                     scnt_nxt  = SCNT_LOAD;
                  end
               end else if (md_haz) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end else if (halt_op) begin
                  state_nxt = ST_HALT;
               end
            end
            ST_STALL: begin
               if (branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  state_nxt   = ST_RUN;
                  scnt_nxt    = '0;
               end else begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  scnt_nxt    = scnt - SCNT_W'(1);
                  if (scnt == SCNT_W'(1)) state_nxt = ST_RUN;
               end
            end
            ST_HALT: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               halted      = 1'b1;
            end
            default: begin
               state_nxt = ST_RUN;
               scnt_nxt  = '0;
            end
         endcase
      end
   end

   // Saturating count of cycles lost to stalls (halt cycles excluded)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (!pc_write && (state != ST_HALT) && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule
